scramble_seq: RTL and testbench
===============================

# scramble_seq

Sequencer directly downstream of the 4-bit LFSR random source. It requests random nibbles, filters them into legal face-move codes and buffers accepted moves in a small FIFO. It streams exactly SEQ_LEN moves per start command to the move executor over a valid/ready handshake.

## Interface
- SEQ_LEN, 20: moves per scramble; legal range 1..63
- FIFO_DEPTH, 4: move buffer entries; power of two, 2..16
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-low
- start  input  1  one-cycle request for a new scramble; ignored while busy=1
- rnd_in  input  4  random nibble from the LFSR stage
- rnd_en  input  1  rnd_in valid strobe from the LFSR stage
- rng_gen  output  1  one-cycle request to the LFSR stage for a new nibble
- move_out  output  4  FIFO head move code: face = move_out[3:1] (0..5), dir = move_out[0]
- move_valid  output  1  move_out valid; equals FIFO not empty
- move_ready  input  1  consumer accepts move_out when move_valid=1 && move_ready=1
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse when the final move is popped

## Operation
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE: on start=1, clear gen_cnt and last_face_vld, then go to REQ. busy=1 from the next cycle.
- REQ: if the FIFO has a free entry, assert rng_gen for one cycle and go to WAIT. If the FIFO is full, stay in REQ with rng_gen=0.
- WAIT: ignore rnd_in until rnd_en=1. On rnd_en=1, evaluate rnd_in in the same cycle:
  - rnd_in >= 12: reject.
  - rnd_in[3:1] == last_face with last_face_vld=1: reject (macro-dependent, see Configuration).
  - Otherwise accept: push rnd_in, set last_face = rnd_in[3:1], set last_face_vld=1, increment gen_cnt.
  - After evaluation, go to DRAIN if gen_cnt (post-increment) == SEQ_LEN, else go to REQ.
- DRAIN: issue no requests. When the FIFO is empty, pulse done, drop busy and go to IDLE. done and the pop of the last move occur in the same cycle.
- rnd_en outside WAIT is ignored.
- FIFO: push and pop may occur in the same cycle. A push only ever occurs when space was verified in REQ. The FIFO never overflows, and no pop occurs when empty.
- gen_cnt width is $clog2(SEQ_LEN+1). It never exceeds SEQ_LEN.
- start during busy=1 has no effect. The sequence is never restarted mid-flight.
- Reset values: rng_gen=0, move_valid=0, move_out=0, busy=0, done=0, FSM=IDLE, FIFO empty, gen_cnt=0, last_face_vld=0. Reset mid-scramble discards all buffered moves.

## Timing
- start at cycle T → REQ at T+1 with rng_gen=1 → WAIT at T+2. With the LFSR stage, rnd_en arrives at T+2.
- Accepted nibble sampled at cycle N → move_valid=1 at N+1 if the FIFO was empty.
- Minimum of 2 cycles per attempt; each rejection costs a further 2 cycles.
- move_out and move_valid are registered. They hold stable while move_valid=1 && move_ready=0.
- done asserts in the cycle of the final handshake. busy=0 from the following cycle.

## Configuration
- SCRAMBLE_REJECT_SAME_FACE_EN
  - Defined: a nibble whose face equals the previously accepted face is rejected, so no two consecutive moves share a face.
  - Undefined: only codes 12..15 are rejected, and last_face logic is removed.

## Structure
- Package scramble_pkg holds:
  - FSM state enum.
  - Move field widths: MOVE_W=4, FACE_W=3.
  - NUM_MOVES=12 and face constants.
- Sub-module move_fifo: parameterised by depth and width, with push, pop, full, empty, head outputs and synchronous active-low reset.

## Test plan
- Reset, then start with move_ready=1 tied high and the LFSR model attached → exactly 20 handshakes, one done pulse, busy=1 for the whole span, no move code >11.
- Drive rnd_in = 13, then 5 → 13 dropped and a second rng_gen issued; move_out=5 appears 1 cycle after 5 is sampled.
- With macro defined, drive 4 then 5 (both face 2), then 7 → 5 rejected, sequence is 4, 7. With macro undefined → sequence is 4, 5, 7.
- Hold move_ready=0 with FIFO_DEPTH=4 → 4 entries fill, rng_gen stays 0, move_out stable. Release → 20 moves total arrive in order.
- Pulse start at mid-scramble → ignored, gen_cnt unaffected, total remains 20.
- Assert rst=0 for 1 cycle after 7 moves → all outputs return to reset values, FIFO empty, no done. A new start produces a full 20-move sequence.

Source files
------------

// File: rtl/scramble_pkg.sv
// scramble_pkg: shared types and constants for the scramble sequencer.
// A move code is {face[2:0], dir}; faces 0..5 give legal codes 0..11.
package scramble_pkg;

    localparam int MOVE_W    = 4;
    localparam int FACE_W    = 3;
    localparam int NUM_MOVES = 12;
    localparam int NUM_FACES = 6;

    localparam logic [FACE_W-1:0] FACE_U = 3'd0;
    localparam logic [FACE_W-1:0] FACE_D = 3'd1;
    localparam logic [FACE_W-1:0] FACE_F = 3'd2;
    localparam logic [FACE_W-1:0] FACE_B = 3'd3;
    localparam logic [FACE_W-1:0] FACE_L = 3'd4;
    localparam logic [FACE_W-1:0] FACE_R = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_e;

    function automatic logic is_legal_move(input logic [MOVE_W-1:0] code);
        return code < MOVE_W'(NUM_MOVES);
    endfunction

    function automatic logic [FACE_W-1:0] move_face(input logic [MOVE_W-1:0] code);
        return code[MOVE_W-1:1];
    endfunction

endpackage

// File: rtl/move_fifo.sv
// move_fifo: small circular buffer for accepted move codes.
// DEPTH must be a power of two so the pointers wrap naturally.
// last_o flags exactly one entry left, used to spot the final pop.
module move_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             last_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign last_o  = (count_q == CNT_W'(1));
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage, pointers and occupancy; reset clears contents so the head reads zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/scramble_seq.sv
// scramble_seq: requests nibbles from the LFSR stage, keeps legal move codes
// and streams SEQ_LEN of them per start through a valid/ready FIFO.
// Optional feature macro: SCRAMBLE_REJECT_SAME_FACE_EN (reject a move whose
// face repeats the previously accepted face).
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | waiting for start; busy low
//  ST_REQ   | request a nibble once the FIFO has a free entry
//  ST_WAIT  | waiting for rnd_en; evaluate and maybe push the nibble
//  ST_DRAIN | all moves generated; done on the pop of the last one
module scramble_seq
    import scramble_pkg::*;
#(
    parameter int SEQ_LEN    = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MOVE_W-1:0] rnd_in,
    input  logic              rnd_en,
    output logic              rng_gen,
    output logic [MOVE_W-1:0] move_out,
    output logic              move_valid,
    input  logic              move_ready,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(SEQ_LEN + 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] gen_cnt_q, gen_cnt_d;
    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_last;

`ifdef SCRAMBLE_REJECT_SAME_FACE_EN
    logic [FACE_W-1:0] last_face_q, last_face_d;
    logic              last_face_vld_q, last_face_vld_d;

    assign accept = is_legal_move(rnd_in) &&
                    !(last_face_vld_q && (move_face(rnd_in) == last_face_q));
`else
    assign accept = is_legal_move(rnd_in);
`endif

    assign move_valid = !fifo_empty;
    assign pop        = move_valid && move_ready;
    assign busy       = (state_q != ST_IDLE);

    // State, generated-move count and last-face history registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            gen_cnt_q <= '0;
`ifdef SCRAMBLE_REJECT_SAME_FACE_EN
            last_face_q     <= '0;
            last_face_vld_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gen_cnt_q <= gen_cnt_d;
`ifdef SCRAMBLE_REJECT_SAME_FACE_EN
            last_face_q     <= last_face_d;
            last_face_vld_q <= last_face_vld_d;
`endif
        end
    end

    // Next-state, request, push and done decode.
    always_comb begin
        state_d   = state_q;
        gen_cnt_d = gen_cnt_q;
        rng_gen   = 1'b0;
        push      = 1'b0;
        done      = 1'b0;
`ifdef SCRAMBLE_REJECT_SAME_FACE_EN
        last_face_d     = last_face_q;
        last_face_vld_d = last_face_vld_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    gen_cnt_d = '0;
`ifdef SCRAMBLE_REJECT_SAME_FACE_EN
                    last_face_vld_d = 1'b0;
`endif
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!fifo_full) begin
                    rng_gen = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rnd_en) begin
                    if (accept) begin
                        push      = 1'b1;
                        gen_cnt_d = gen_cnt_q + CNT_W'(1);
`ifdef SCRAMBLE_REJECT_SAME_FACE_EN
                        last_face_d     = move_face(rnd_in);
                        last_face_vld_d = 1'b1;
`endif
                    end
                    state_d = (gen_cnt_d == CNT_W'(SEQ_LEN)) ? ST_DRAIN : ST_REQ;
                end
            end
            ST_DRAIN: begin
                // The final pop empties the FIFO; done coincides with it.
                if (pop && fifo_last) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    move_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MOVE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (rnd_in),
        .head_o  (move_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .last_o  (fifo_last)
    );

endmodule

// File: tb/tb_scramble_seq.sv
// tb_scramble_seq: randomized bench with an LFSR-stage responder and a
// queue-based reference of the move stream.
module tb_scramble_seq;

    localparam int SEQ_LEN = 20;
    localparam int DEPTH   = 4;
`ifdef SCRAMBLE_REJECT_SAME_FACE_EN
    localparam bit REJ_SAME = 1'b1;
`else
    localparam bit REJ_SAME = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] rnd_in = 4'd0;
    logic       rnd_en = 1'b0;
    logic       rng_gen;
    logic [3:0] move_out;
    logic       move_valid;
    logic       move_ready = 1'b0;
    logic       busy;
    logic       done;

    scramble_seq #(.SEQ_LEN(SEQ_LEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rnd_in     (rnd_in),
        .rnd_en     (rnd_en),
        .rng_gen    (rng_gen),
        .move_out   (move_out),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [3:0] exp_q[$];
    logic [3:0] force_q[$];
    bit         busy_exp, outstanding, have_last, rng_expect, after_reset;
    logic [2:0] last_face;
    int         lat_cnt, accepted, popped, max_lat, ready_mode, hs_count;
    bit         start_req, rst_req, saw_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        bit         hs, done_exp, deliver, acc;
        logic [3:0] nib;
        @(negedge clk);
        rst = !rst_req;
        rst_req = 1'b0;
        start = start_req;
        start_req = 1'b0;
        deliver = 1'b0;
        rnd_en = 1'b0;
        rnd_in = 4'($urandom);
        if (outstanding) begin
            if (lat_cnt == 0) begin
                deliver = 1'b1;
                rnd_en = 1'b1;
                if (force_q.size() > 0) rnd_in = force_q.pop_front();
                else rnd_in = 4'($urandom_range(0, 15));
            end else begin
                lat_cnt--;
            end
        end else if ($urandom_range(0, 5) == 0) begin
            rnd_en = 1'b1;  // stray strobe while no request is open
        end
        case (ready_mode)
            0:       move_ready = 1'b1;
            1:       move_ready = 1'($urandom_range(0, 1));
            default: move_ready = 1'b0;
        endcase
        if (!rst) move_ready = 1'b0;
        nib = rnd_in;
        #1;
        if (!rst) begin
            check("done_in_rst", done, 0);
            exp_q.delete();
            busy_exp = 0; outstanding = 0; accepted = 0; popped = 0;
            have_last = 0; rng_expect = 0; after_reset = 1;
            return;
        end
        if (after_reset) begin
            check("rst_rng_gen", rng_gen, 0);
            check("rst_move_out", move_out, 0);
            after_reset = 0;
        end
        check("busy", busy, busy_exp);
        check("move_valid", move_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("move_out", move_out, exp_q[0]);
        hs = (exp_q.size() != 0) && move_ready;
        done_exp = hs && busy_exp && (popped + 1 == SEQ_LEN);
        check("done", done, done_exp);
        if (rng_expect) check("rng_gen_after_start", rng_gen, 1);
        if (rng_gen)
            check("rng_gen_legal", {busy_exp, outstanding, exp_q.size() < DEPTH, accepted < SEQ_LEN}, 4'b1011);
        if (done) saw_done = 1;
        // model update for the coming edge
        rng_expect = 0;
        if (hs) begin
            void'(exp_q.pop_front());
            popped++;
            hs_count++;
        end
        if (done_exp) busy_exp = 0;
        if (deliver) begin
            outstanding = 0;
            acc = (nib < 12) && !(REJ_SAME && have_last && (nib[3:1] == last_face));
            if (acc) begin
                exp_q.push_back(nib);
                accepted++;
                have_last = 1;
                last_face = nib[3:1];
            end
        end
        if (rng_gen && busy_exp) begin
            outstanding = 1;
            lat_cnt = $urandom_range(0, max_lat);
        end
        if (start && !busy_exp) begin
            busy_exp = 1; accepted = 0; popped = 0; have_last = 0; rng_expect = 1;
        end
    endtask

    task automatic run_scramble(input int base_mode, input int hold_cycles,
                                input bit mid_start, input int reset_after);
        int c;
        bit mid_done;
        saw_done = 0;
        hs_count = 0;
        mid_done = 0;
        ready_mode = (hold_cycles > 0) ? 2 : base_mode;
        start_req = 1;
        step();
        c = 0;
        while (!saw_done && c < 3000) begin
            if (c == hold_cycles) ready_mode = base_mode;
            if (mid_start && !mid_done && hs_count >= 5) begin
                start_req = 1;
                mid_done = 1;
            end
            if (reset_after > 0 && hs_count >= reset_after) begin
                rst_req = 1;
                step();
                repeat (4) step();
                check("no_done_after_rst", saw_done, 0);
                return;
            end
            step();
            c++;
        end
        check("scramble_done", saw_done, 1);
        repeat (2) step();
    endtask

    initial begin
        exp_q.delete();
        force_q.delete();
        busy_exp = 0; outstanding = 0; have_last = 0; rng_expect = 0; after_reset = 0;
        last_face = '0; lat_cnt = 0; accepted = 0; popped = 0; hs_count = 0;
        max_lat = 0; ready_mode = 0; start_req = 0; rst_req = 0; saw_done = 0;

        rst_req = 1;
        step();
        repeat (3) step();

        // nominal run, consumer always ready
        run_scramble(0, 0, 0, 0);

        // rejected code 13 followed by 5
        force_q = '{4'd13, 4'd5};
        run_scramble(0, 0, 0, 0);

        // same-face pair 4,5 then 7
        force_q = '{4'd4, 4'd5, 4'd7};
        run_scramble(0, 0, 0, 0);

        // consumer stalls until the FIFO fills, then releases
        force_q = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10};
        run_scramble(0, 40, 0, 0);

        // start pulse mid-scramble is ignored
        run_scramble(0, 0, 1, 0);

        // reset after 7 moves, then a fresh full scramble
        run_scramble(0, 0, 0, 7);
        run_scramble(0, 0, 0, 0);

        // randomized handshake and response latency
        max_lat = 2;
        for (int k = 0; k < 6; k++) begin
            run_scramble(1, 0, (k % 2) == 1, 0);
        end
        max_lat = 1;
        run_scramble(1, 25, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
